// File: rtl/sd_clk_divider.sv
// SD card clock generator: divides clk by a programmable period count, with
// glitch-free count changes at period boundaries and clean start/stop (parks low).
module sd_clk_divider #(
   parameter int          WIDTH         = 16,
   parameter int unsigned DEFAULT_COUNT = 125
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] count,
   input  logic             enable,
   output logic             sd_clk,
   output logic             rise_stb,
   output logic             fall_stb,
   output logic             running,
   output logic             cfg_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] counter, counter_nxt;
   logic [WIDTH-1:0] active_n, active_n_nxt;
   logic [WIDTH-1:0] pend_n;
   logic             pend, pend_nxt;
   logic             sd_clk_nxt, rise_nxt, fall_nxt, running_nxt, cfg_err_nxt;

   logic             load_ok;
   logic             low_end;
   logic             pend_set;
   logic [WIDTH-1:0] boundary_n;

   // A period of 1 cannot be split into two phases, so it runs as 2.
   function automatic logic [WIDTH-1:0] norm_n(input logic [WIDTH-1:0] n);
      return (n < WIDTH'(2)) ? WIDTH'(2) : n;
   endfunction

   function automatic logic [WIDTH-1:0] low_len(input logic [WIDTH-1:0] n);
      return norm_n(n) >> 1;
   endfunction

   function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] n);
      return norm_n(n) - low_len(n);
   endfunction

   assign load_ok  = load && (count != '0);
   assign low_end  = (state == LOW) && (counter == '0);
   assign pend_set = load_ok && (state != IDLE) && !low_end;

   // Count for the period that starts at a LOW boundary: a same-cycle load
   // beats a pending one, which beats the current value.
   assign boundary_n = load_ok ? count : (pend ? pend_n : active_n);

   always_comb begin
      state_nxt    = state;
      counter_nxt  = counter;
      active_n_nxt = active_n;
      pend_nxt     = pend;
      sd_clk_nxt   = sd_clk;
      rise_nxt     = 1'b0;
      fall_nxt     = 1'b0;
      running_nxt  = running;
      cfg_err_nxt  = cfg_err;

      if (load) begin
         cfg_err_nxt = (count == '0);
      end
      if (pend_set) begin
         pend_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            sd_clk_nxt  = 1'b0;
            running_nxt = 1'b0;
            if (load_ok) begin
               active_n_nxt = count;
            end
            if (enable) begin
               state_nxt   = HIGH;
               sd_clk_nxt  = 1'b1;
               rise_nxt    = 1'b1;
               running_nxt = 1'b1;
               counter_nxt = high_len(load_ok ? count : active_n) - WIDTH'(1);
            end
         end

         // enable is deliberately ignored here so a high phase always completes
         HIGH: begin
            if (counter != '0) begin
               counter_nxt = counter - WIDTH'(1);
            end else begin
               state_nxt   = LOW;
               sd_clk_nxt  = 1'b0;
               fall_nxt    = 1'b1;
               counter_nxt = low_len(active_n) - WIDTH'(1);
            end
         end

         LOW: begin
            if (counter != '0) begin
               counter_nxt = counter - WIDTH'(1);
            end else begin
               active_n_nxt = boundary_n;
               pend_nxt     = 1'b0;
               if (enable) begin
                  state_nxt   = HIGH;
                  sd_clk_nxt  = 1'b1;
                  rise_nxt    = 1'b1;
                  counter_nxt = high_len(boundary_n) - WIDTH'(1);
               end else begin
                  state_nxt   = IDLE;
                  running_nxt = 1'b0;
                  counter_nxt = '0;
               end
            end
         end

         default: begin
            state_nxt   = IDLE;
            sd_clk_nxt  = 1'b0;
            running_nxt = 1'b0;
            counter_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         counter  <= '0;
         active_n <= WIDTH'(DEFAULT_COUNT);
         pend     <= 1'b0;
         sd_clk   <= 1'b0;
         rise_stb <= 1'b0;
         fall_stb <= 1'b0;
         running  <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         counter  <= counter_nxt;
         active_n <= active_n_nxt;
         pend     <= pend_nxt;
         sd_clk   <= sd_clk_nxt;
         rise_stb <= rise_nxt;
         fall_stb <= fall_nxt;
         running  <= running_nxt;
         cfg_err  <= cfg_err_nxt;
      end
   end

   // Pending count is only meaningful while pend is set, so it needs no reset.
   always_ff @(posedge clk) begin
      if (pend_set) begin
         pend_n <= count;
      end
   end

endmodule

// File: tb/tb_sd_clk_divider.sv
// Directed bench for sd_clk_divider: phase lengths, strobes, count reloads,
// stop/start and asynchronous reset, against hand-computed values.
module tb_sd_clk_divider;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             load;
   logic [WIDTH-1:0] count;
   logic             enable;
   logic             sd_clk;
   logic             rise_stb;
   logic             fall_stb;
   logic             running;
   logic             cfg_err;

   int n_cmp = 0;
   int n_err = 0;
   int n;

   always #10 clk = ~clk;

   sd_clk_divider #(
      .WIDTH(WIDTH),
      .DEFAULT_COUNT(125)
   ) dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .count(count),
      .enable(enable),
      .sd_clk(sd_clk),
      .rise_stb(rise_stb),
      .fall_stb(fall_stb),
      .running(running),
      .cfg_err(cfg_err)
   );

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Counts consecutive sampled cycles at level lvl while running, bounded.
   task automatic run_len(input logic lvl, output int len);
      len = 0;
      while (sd_clk === lvl && running === 1'b1 && len < 1000) begin
         len++;
         tick();
      end
   endtask

   task automatic load_pulse(input logic [WIDTH-1:0] c);
      load  = 1'b1;
      count = c;
      tick();
      load  = 1'b0;
   endtask

   initial begin
      reset  = 1'b0;
      load   = 1'b0;
      enable = 1'b1;
      count  = '0;
      repeat (3) tick();

      check("rst_sd_clk",  sd_clk,   0);
      check("rst_rise",    rise_stb, 0);
      check("rst_fall",    fall_stb, 0);
      check("rst_running", running,  0);
      check("rst_cfg_err", cfg_err,  0);

      // Default 125-cycle period straight out of reset
      reset = 1'b1;
      tick();
      check("a_first_rise_clk", sd_clk,   1);
      check("a_first_rise_stb", rise_stb, 1);
      check("a_running",        running,  1);
      run_len(1'b1, n);  check("a_high_63", n, 63);
      check("a_fall_stb", fall_stb, 1);
      check("a_fall_excl", rise_stb, 0);
      run_len(1'b0, n);  check("a_low_62", n, 62);
      check("a_rise_stb", rise_stb, 1);
      check("a_rise_excl", fall_stb, 0);

      // Stop mid high phase: both phases complete, then park low
      repeat (10) tick();
      enable = 1'b0;
      run_len(1'b1, n);  check("b_high_rest", n, 53);
      run_len(1'b0, n);  check("b_low_full", n, 62);
      check("b_stopped_running", running, 0);
      repeat (5) tick();
      check("b_parked_low", sd_clk, 0);
      check("b_idle_running", running, 0);

      // Load 4 in IDLE, then start: 1,1,0,0
      load_pulse(16'd4);
      enable = 1'b1;
      tick();
      check("c_rise_1clk", sd_clk, 1);
      check("c_rise_stb", rise_stb, 1);
      run_len(1'b1, n);  check("c_high_2", n, 2);
      run_len(1'b0, n);  check("c_low_2", n, 2);

      // Load 5 while running: current period stays 2/2, then 3/2
      load_pulse(16'd5);
      run_len(1'b1, n);  check("d_high_rest", n, 1);
      run_len(1'b0, n);  check("d_low_old", n, 2);
      check("d_rise_stb", rise_stb, 1);
      run_len(1'b1, n);  check("d_high_3", n, 3);
      check("d_fall_stb", fall_stb, 1);
      run_len(1'b0, n);  check("d_low_2", n, 2);

      // Count 1 behaves as 2
      load_pulse(16'd1);
      run_len(1'b1, n);  check("e_high_rest", n, 2);
      run_len(1'b0, n);  check("e_low_old", n, 2);
      run_len(1'b1, n);  check("e_high_1", n, 1);
      run_len(1'b0, n);  check("e_low_1", n, 1);

      // Back to 125, loaded during the single-cycle high phase
      load_pulse(16'd125);
      run_len(1'b0, n);  check("f_low_old", n, 1);
      run_len(1'b1, n);  check("f_high_63", n, 63);
      run_len(1'b0, n);  check("f_low_62", n, 62);

      // Load 2 mid high at N=125: period finishes 63/62, then 1/1
      repeat (20) tick();
      load_pulse(16'd2);
      run_len(1'b1, n);  check("g_high_rest", n, 42);
      run_len(1'b0, n);  check("g_low_full", n, 62);
      run_len(1'b1, n);  check("g_high_1a", n, 1);
      run_len(1'b0, n);  check("g_low_1a", n, 1);
      run_len(1'b1, n);  check("g_high_1b", n, 1);

      // Load on the LOW-phase end cycle applies to the very next period
      load_pulse(16'd6);
      check("h_rise_stb", rise_stb, 1);
      run_len(1'b1, n);  check("h_high_3", n, 3);
      run_len(1'b0, n);  check("h_low_3", n, 3);

      // Count 0 is rejected and flagged; period unchanged
      load_pulse(16'd0);
      check("i_cfg_err_set", cfg_err, 1);
      run_len(1'b1, n);  check("i_high_rest", n, 2);
      run_len(1'b0, n);  check("i_low_3", n, 3);
      tick();
      check("i_mid_high", sd_clk, 1);

      // Asynchronous reset in the middle of a high phase
      reset = 1'b0;
      #1;
      check("j_async_sd_clk", sd_clk,   0);
      check("j_async_rise",   rise_stb, 0);
      check("j_async_fall",   fall_stb, 0);
      check("j_async_running", running, 0);
      check("j_async_cfg_err", cfg_err, 0);
      tick();
      reset = 1'b1;
      tick();
      check("j_restart_rise", rise_stb, 1);
      run_len(1'b1, n);  check("j_default_high", n, 63);
      run_len(1'b0, n);  check("j_default_low", n, 62);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
